// File: rtl/gemm_array.sv
// rtl/gemm_array.sv - streaming C_DIM x C_DIM integer matrix multiplier, C = A x B
// Column-per-PE MAC array; results buffered per PE and read out row-major under i_rd_output.
module gemm_array #(
    parameter int C_DATA_WIDTH    = 32,
    parameter int C_DIM           = 4,
    parameter int C_NUM_PE        = 4,
    parameter int C_RAM_IN_DELAY  = 1,
    parameter int C_RAM_OUT_DELAY = 1,
    parameter int C_MAC_DELAY     = 1,
    parameter int C_RAM_STYLE     = 1
) (
    input  logic                    clock,
    input  logic                    i_reset,
    input  logic [C_DATA_WIDTH-1:0] Ain_data,
    input  logic                    Ain_valid,
    input  logic [C_DATA_WIDTH-1:0] Bin_data,
    input  logic                    Bin_valid,
    output logic [C_DATA_WIDTH-1:0] Aout_data,
    output logic                    Aout_valid,
    output logic                    Bout_valid,
    input  logic                    i_rd_output,
    output logic                    o_rd_output
);
    localparam int DW  = C_DATA_WIDTH;
    localparam int N   = C_DIM;
    localparam int P   = C_NUM_PE;
    localparam int AW  = (N > 1) ? $clog2(N) : 1;
    localparam int RW  = $clog2(N + 1);
    localparam int RID = (C_RAM_IN_DELAY > 0) ? C_RAM_IN_DELAY : 1;
    localparam int ROD = (C_RAM_OUT_DELAY > 0) ? C_RAM_OUT_DELAY : 1;
    localparam int MD  = (C_MAC_DELAY > 0) ? C_MAC_DELAY : 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(N);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_COMPUTE,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic          vld;
        logic          first;
        logic          last;
        logic [AW-1:0] row;
    } tag_t;

    state_t state;

    logic [DW-1:0] a_mem [N][N];
    logic [DW-1:0] b_mem [P][N];
    logic [DW-1:0] c_mem [P][N];

    logic [RW-1:0] ld_row;
    logic [AW-1:0] ld_col;
    logic          beat;
    logic          ld_a_we;
    logic          ld_b_we;

    logic          iss_active;
    logic [AW-1:0] iss_row;
    logic [AW-1:0] iss_k;

    tag_t          in_tag  [RID];
    logic [DW-1:0] in_a    [RID];
    logic [DW-1:0] in_b    [RID][P];
    tag_t          mac_tag [MD];
    logic [DW-1:0] mac_p   [MD][P];
    logic [DW-1:0] acc     [P];
    logic [DW-1:0] mac_sum [P];
    tag_t          acc_tag;

    logic [AW-1:0] rd_row;
    logic [AW-1:0] rd_col;
    logic          rd_all;
    logic          rd_go;
    logic          rd_last;
    logic          rq_vld;
    logic          rq_last;
    logic          ro_vld  [ROD];
    logic          ro_last [ROD];
    logic [DW-1:0] ro_dly  [ROD];

    // Beat k: B row = ld_row (valid while < N), A row = ld_row - 1 (the first N beats are A padding).
    assign beat    = (state == ST_LOAD) && Ain_valid && Bin_valid;
    assign ld_b_we = beat && (ld_row < LAST_ROW);
    assign ld_a_we = beat && (ld_row != '0);

    assign acc_tag = mac_tag[MD-1];
    assign rd_go   = (state == ST_DONE) && i_rd_output && !rd_all;
    assign rd_last = (rd_row == LAST_IDX) && (rd_col == LAST_IDX);

    always_comb begin
        for (int j = 0; j < P; j++) begin
            mac_sum[j] = acc_tag.first ? mac_p[MD-1][j] : acc[j] + mac_p[MD-1][j];
        end
    end

    // Storage and datapath registers carry no reset; validity travels in the tag pipelines.
    always_ff @(posedge clock) begin
        if (ld_b_we) begin
            b_mem[ld_col][AW'(ld_row)] <= Bin_data;
        end
        if (ld_a_we) begin
            a_mem[AW'(ld_row - 1'b1)][ld_col] <= Ain_data;
        end

        in_a[0] <= a_mem[iss_row][iss_k];
        for (int j = 0; j < P; j++) begin
            in_b[0][j] <= b_mem[j][iss_k];
        end
        for (int s = 1; s < RID; s++) begin
            in_a[s] <= in_a[s-1];
            for (int j = 0; j < P; j++) begin
                in_b[s][j] <= in_b[s-1][j];
            end
        end

        for (int j = 0; j < P; j++) begin
            mac_p[0][j] <= in_a[RID-1] * in_b[RID-1][j];
            for (int s = 1; s < MD; s++) begin
                mac_p[s][j] <= mac_p[s-1][j];
            end
            if (acc_tag.vld && acc_tag.last) begin
                c_mem[j][acc_tag.row] <= mac_sum[j];
            end
        end
    end

    // Both result-read structures give the same request-to-data latency.
    if (C_RAM_STYLE != 0) begin : g_c_bram
        logic [AW-1:0] rq_row;
        logic [AW-1:0] rq_col;

        always_ff @(posedge clock) begin
            if (rd_go) begin
                rq_row <= rd_row;
                rq_col <= rd_col;
            end
            ro_dly[0] <= c_mem[rq_col][rq_row];
            for (int s = 1; s < ROD; s++) begin
                ro_dly[s] <= ro_dly[s-1];
            end
        end
    end else begin : g_c_dist
        logic [DW-1:0] rq_word;

        always_ff @(posedge clock) begin
            if (rd_go) begin
                rq_word <= c_mem[rd_col][rd_row];
            end
            ro_dly[0] <= rq_word;
            for (int s = 1; s < ROD; s++) begin
                ro_dly[s] <= ro_dly[s-1];
            end
        end
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state       <= ST_LOAD;
            ld_row      <= '0;
            ld_col      <= '0;
            iss_active  <= 1'b0;
            iss_row     <= '0;
            iss_k       <= '0;
            for (int s = 0; s < RID; s++) begin
                in_tag[s] <= '0;
            end
            for (int s = 0; s < MD; s++) begin
                mac_tag[s] <= '0;
            end
            for (int j = 0; j < P; j++) begin
                acc[j] <= '0;
            end
            rd_row      <= '0;
            rd_col      <= '0;
            rd_all      <= 1'b0;
            rq_vld      <= 1'b0;
            rq_last     <= 1'b0;
            for (int s = 0; s < ROD; s++) begin
                ro_vld[s]  <= 1'b0;
                ro_last[s] <= 1'b0;
            end
            Aout_valid  <= 1'b0;
            Aout_data   <= '0;
            Bout_valid  <= 1'b0;
            o_rd_output <= 1'b0;
        end else begin
            Bout_valid  <= Bin_valid;
            o_rd_output <= i_rd_output;

            in_tag[0] <= '{vld: iss_active, first: (iss_k == '0), last: (iss_k == LAST_IDX), row: iss_row};
            for (int s = 1; s < RID; s++) begin
                in_tag[s] <= in_tag[s-1];
            end
            mac_tag[0] <= in_tag[RID-1];
            for (int s = 1; s < MD; s++) begin
                mac_tag[s] <= mac_tag[s-1];
            end
            if (acc_tag.vld) begin
                for (int j = 0; j < P; j++) begin
                    acc[j] <= mac_sum[j];
                end
            end

            rq_vld     <= rd_go;
            rq_last    <= rd_go && rd_last;
            ro_vld[0]  <= rq_vld;
            ro_last[0] <= rq_last;
            for (int s = 1; s < ROD; s++) begin
                ro_vld[s]  <= ro_vld[s-1];
                ro_last[s] <= ro_last[s-1];
            end
            Aout_valid <= ro_vld[ROD-1];
            Aout_data  <= ro_vld[ROD-1] ? ro_dly[ROD-1] : '0;

            case (state)
                ST_LOAD: begin
                    if (beat) begin
                        if (ld_col == LAST_IDX) begin
                            ld_col <= '0;
                            if (ld_row == LAST_ROW) begin
                                ld_row     <= '0;
                                state      <= ST_COMPUTE;
                                iss_active <= 1'b1;
                                iss_row    <= '0;
                                iss_k      <= '0;
                            end else begin
                                ld_row <= ld_row + 1'b1;
                            end
                        end else begin
                            ld_col <= ld_col + 1'b1;
                        end
                    end
                end
                ST_COMPUTE: begin
                    if (iss_active) begin
                        if (iss_k == LAST_IDX) begin
                            iss_k <= '0;
                            if (iss_row == LAST_IDX) begin
                                iss_active <= 1'b0;
                            end else begin
                                iss_row <= iss_row + 1'b1;
                            end
                        end else begin
                            iss_k <= iss_k + 1'b1;
                        end
                    end
                    if (acc_tag.vld && acc_tag.last && (acc_tag.row == LAST_IDX)) begin
                        state  <= ST_DONE;
                        rd_row <= '0;
                        rd_col <= '0;
                        rd_all <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (rd_go) begin
                        if (rd_col == LAST_IDX) begin
                            rd_col <= '0;
                            rd_row <= rd_row + 1'b1;
                        end else begin
                            rd_col <= rd_col + 1'b1;
                        end
                        if (rd_last) begin
                            rd_all <= 1'b1;
                        end
                    end
                    if (ro_vld[ROD-1] && ro_last[ROD-1]) begin
                        state <= ST_LOAD;
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_gemm_array.sv
// tb/tb_gemm_array.sv - directed self-checking bench for gemm_array (N=4, all delays 1)
module tb_gemm_array;
    localparam int N  = 4;
    localparam int NN = N * N;

    logic        clock = 1'b0;
    logic        i_reset;
    logic [31:0] Ain_data;
    logic        Ain_valid;
    logic [31:0] Bin_data;
    logic        Bin_valid;
    logic [31:0] Aout_data;
    logic        Aout_valid;
    logic        Bout_valid;
    logic        i_rd_output;
    logic        o_rd_output;

    int n_tests = 0;
    int n_fail  = 0;
    logic prev_bv = 1'b0;
    logic prev_rd = 1'b0;

    logic [31:0] mat_a [NN];
    logic [31:0] mat_b [NN];
    logic [31:0] exp_c [NN];

    always #5 clock = ~clock;

    gemm_array #(
        .C_DATA_WIDTH   (32),
        .C_DIM          (N),
        .C_NUM_PE       (N),
        .C_RAM_IN_DELAY (1),
        .C_RAM_OUT_DELAY(1),
        .C_MAC_DELAY    (1),
        .C_RAM_STYLE    (1)
    ) dut (
        .clock      (clock),
        .i_reset    (i_reset),
        .Ain_data   (Ain_data),
        .Ain_valid  (Ain_valid),
        .Bin_data   (Bin_data),
        .Bin_valid  (Bin_valid),
        .Aout_data  (Aout_data),
        .Aout_valid (Aout_valid),
        .Bout_valid (Bout_valid),
        .i_rd_output(i_rd_output),
        .o_rd_output(o_rd_output)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One clock: sample at the falling edge, then drive inputs for the next rising edge.
    task automatic cycle(input logic av, input logic bv, input logic [31:0] ad, input logic [31:0] bd,
                         input logic rd, input logic quiet);
        @(negedge clock);
        check("bout_valid_echo", 32'(Bout_valid), 32'(prev_bv));
        check("o_rd_output_echo", 32'(o_rd_output), 32'(prev_rd));
        if (quiet) begin
            check("aout_valid_idle", 32'(Aout_valid), 32'd0);
        end
        Ain_valid   = av;
        Bin_valid   = bv;
        Ain_data    = ad;
        Bin_data    = bd;
        i_rd_output = rd;
        prev_bv     = bv;
        prev_rd     = rd;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        end
    endtask

    task automatic load_mats(input bit gaps, input logic rd);
        logic [31:0] ad;
        logic [31:0] bd;
        for (int k = 0; k < N * (N + 1); k++) begin
            if (gaps && k == 9) begin
                for (int g = 0; g < 3; g++) begin
                    cycle(1'b0, 1'b0, 32'hDEAD0000 + g, 32'hBEEF0000 + g, rd, 1'b1);
                end
                cycle(1'b0, 1'b1, 32'h11111111, 32'h22222222, rd, 1'b1);
                cycle(1'b1, 1'b0, 32'h33333333, 32'h44444444, rd, 1'b1);
            end
            if (k < N) ad = 32'hA5A50000 + k;
            else       ad = mat_a[k-N];
            if (k < NN) bd = mat_b[k];
            else        bd = 32'h5A5A0000 + k;
            cycle(1'b1, 1'b1, ad, bd, rd, 1'b1);
        end
        cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    endtask

    // A request driven at sample s shows up at sample s+3 (request edge + 2 register stages).
    task automatic read_out(input int pause_at, input int pause_len);
        logic rd_h  [48];
        int   idx_h [48];
        int   reqs;
        logic rd;
        reqs = 0;
        for (int s = 0; s < 48; s++) begin
            rd = !(s >= pause_at && s < pause_at + pause_len);
            cycle(1'b0, 1'b0, 32'd0, 32'd0, rd, 1'b0);
            if (s >= 3 && rd_h[s-3] && idx_h[s-3] < NN) begin
                check("aout_valid", 32'(Aout_valid), 32'd1);
                check($sformatf("c[%0d]", idx_h[s-3]), Aout_data, exp_c[idx_h[s-3]]);
            end else begin
                check("aout_valid_gap", 32'(Aout_valid), 32'd0);
            end
            rd_h[s]  = rd;
            idx_h[s] = reqs;
            if (rd && reqs < NN) reqs++;
        end
        cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    endtask

    task automatic set_ident_times_seq();
        for (int i = 0; i < NN; i++) begin
            mat_a[i] = (i / N == i % N) ? 32'd1 : 32'd0;
            mat_b[i] = 32'(i + 1);
            exp_c[i] = 32'(i + 1);
        end
    endtask

    task automatic set_seq_times_ident();
        for (int i = 0; i < NN; i++) begin
            mat_a[i] = 32'(i + 1);
            mat_b[i] = (i / N == i % N) ? 32'd1 : 32'd0;
            exp_c[i] = 32'(i + 1);
        end
    endtask

    initial begin
        i_reset     = 1'b0;
        Ain_valid   = 1'b1;
        Bin_valid   = 1'b1;
        Ain_data    = 32'd0;
        Bin_data    = 32'd0;
        i_rd_output = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_aout_valid", 32'(Aout_valid), 32'd0);
        check("rst_aout_data", Aout_data, 32'd0);
        check("rst_bout_valid", 32'(Bout_valid), 32'd0);
        check("rst_o_rd_output", 32'(o_rd_output), 32'd0);
        Ain_valid   = 1'b0;
        Bin_valid   = 1'b0;
        i_rd_output = 1'b0;
        @(negedge clock);
        i_reset = 1'b1;

        // Identity x (1..16): C = B, contiguous readout.
        set_ident_times_seq();
        load_mats(1'b0, 1'b0);
        idle(25);
        read_out(100, 0);

        // (1..16) x identity: C = A; read-enable held during LOAD must do nothing.
        set_seq_times_ident();
        load_mats(1'b0, 1'b1);
        idle(25);
        read_out(100, 0);

        // All 2 x all 3: every element 4*2*3 = 24.
        for (int i = 0; i < NN; i++) begin
            mat_a[i] = 32'd2;
            mat_b[i] = 32'd3;
            exp_c[i] = 32'd24;
        end
        load_mats(1'b0, 1'b0);
        idle(25);
        read_out(100, 0);

        // Product truncation: 0xFFFFFFFF * 2 wraps to 0xFFFFFFFE.
        for (int i = 0; i < NN; i++) begin
            mat_a[i] = 32'd0;
            mat_b[i] = 32'd0;
            exp_c[i] = 32'd0;
        end
        mat_a[0] = 32'hFFFFFFFF;
        mat_b[0] = 32'd2;
        exp_c[0] = 32'hFFFFFFFE;
        load_mats(1'b0, 1'b0);
        idle(25);
        read_out(100, 0);

        // Gapped/half-valid beats, then a paused readout after 5 words.
        set_ident_times_seq();
        load_mats(1'b1, 1'b0);
        idle(25);
        read_out(5, 4);

        // Reset during COMPUTE, then a fresh load must produce the new product.
        for (int i = 0; i < NN; i++) begin
            mat_a[i] = 32'd2;
            mat_b[i] = 32'd3;
        end
        load_mats(1'b0, 1'b0);
        idle(5);
        cycle(1'b0, 1'b1, 32'd0, 32'd7, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        i_reset     = 1'b0;
        Bin_valid   = 1'b1;
        i_rd_output = 1'b1;
        #1;
        check("midrst_bout_valid", 32'(Bout_valid), 32'd0);
        check("midrst_o_rd_output", 32'(o_rd_output), 32'd0);
        check("midrst_aout_valid", 32'(Aout_valid), 32'd0);
        check("midrst_aout_data", Aout_data, 32'd0);
        repeat (2) @(negedge clock);
        check("midrst_hold_bout_valid", 32'(Bout_valid), 32'd0);
        Bin_valid   = 1'b0;
        i_rd_output = 1'b0;
        prev_bv     = 1'b0;
        prev_rd     = 1'b0;
        i_reset     = 1'b1;
        set_seq_times_ident();
        load_mats(1'b0, 1'b0);
        idle(25);
        read_out(100, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
